fetch_stage: RTL and testbench



---
 rtl/fetch_stage.sv | 80 ++++++++
 tb/tb_fetch_stage.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// LEGv8 instruction-fetch stage with IF/ID pipeline register.
// Holds the PC, handles branch redirect, stall, flush and a saturating fetch counter.
module fetch_stage #(
  parameter int          N        = 64,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         reset,
  output logic [N-1:0] imem_addr,
  input  logic [31:0]  imem_data,
  input  logic         pcsrc,
  input  logic [N-1:0] pcbranch,
  input  logic         stall,
  input  logic         flush,
  output logic [31:0]  instr_D,
  output logic [N-1:0] pc_D,
  output logic         valid_D,
  output logic [31:0]  fetch_count
);

  logic [N-1:0] pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [N-1:0] pc_id_q, pc_id_d;
  logic         valid_q, valid_d;
  logic [31:0]  cnt_q;
  logic [31:0]  cnt_d;
  logic         load;

  assign load = !flush && !stall;

  // Redirect outranks stall so a taken branch is never lost behind a hazard.
  always_comb begin
    pc_d = pc_q + N'(4);
    if (pcsrc) begin
      pc_d = {pcbranch[N-1:2], 2'b00};
    end else if (stall) begin
      pc_d = pc_q;
    end
  end

  always_comb begin
    instr_d = imem_data;
    pc_id_d = pc_q;
    valid_d = 1'b1;
    if (flush) begin
      instr_d = 32'h0;
      pc_id_d = '0;
      valid_d = 1'b0;
    end else if (stall) begin
      instr_d = instr_q;
      pc_id_d = pc_id_q;
      valid_d = valid_q;
    end
  end

  assign cnt_d = (load && (cnt_q != 32'hFFFF_FFFF)) ? cnt_q + 32'd1 : cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      pc_id_q <= '0;
      valid_q <= 1'b0;
      cnt_q   <= 32'h0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc_id_q <= pc_id_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_addr   = pc_q;
  assign instr_D     = instr_q;
  assign pc_D        = pc_id_q;
  assign valid_D     = valid_q;
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage plus a forced-counter saturation sequence.
module tb_fetch_stage;

  localparam logic [31:0] MAGIC = 32'hF840_8022;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] imem_addr;
  logic [31:0] imem_data;
  logic        pcsrc = 1'b0;
  logic [63:0] pcbranch = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] instr_D;
  logic [63:0] pc_D;
  logic        valid_D;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  fetch_stage #(.N(64), .RESET_PC(64'h0)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .pcsrc       (pcsrc),
    .pcbranch    (pcbranch),
    .stall       (stall),
    .flush       (flush),
    .instr_D     (instr_D),
    .pc_D        (pc_D),
    .valid_D     (valid_D),
    .fetch_count (fetch_count)
  );

  always #5 clk = ~clk;

  // Memory word at A is A xor MAGIC, so address 0 returns 0xF8408022.
  function automatic logic [31:0] w(input logic [63:0] a);
    return a[31:0] ^ MAGIC;
  endfunction

  assign imem_data = w(imem_addr);

  typedef struct {
    logic        rst;
    logic        br;
    logic        st;
    logic        fl;
    logic [63:0] tgt;
    logic [63:0] e_addr;
    logic [31:0] e_instr;
    logic [63:0] e_pc;
    logic        e_valid;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs[23];

  function automatic vec_t mk(input logic rst, input logic br, input logic st, input logic fl,
                              input logic [63:0] tgt, input logic [63:0] ea, input logic [31:0] ei,
                              input logic [63:0] ep, input logic ev, input logic [31:0] ec);
    vec_t v;
    v.rst = rst; v.br = br; v.st = st; v.fl = fl; v.tgt = tgt;
    v.e_addr = ea; v.e_instr = ei; v.e_pc = ep; v.e_valid = ev; v.e_cnt = ec;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic rst, input logic br, input logic st, input logic fl,
                      input logic [63:0] tgt);
    @(negedge clk);
    reset = rst; pcsrc = br; stall = st; flush = fl; pcbranch = tgt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            rst br st fl target                 addr                    instr           pc_D                   v  cnt
    vecs[0]  = mk(1, 0, 0, 0, 64'h0,                  64'h0,                  32'h0,          64'h0,                 0, 0);
    vecs[1]  = mk(0, 0, 0, 0, 64'h0,                  64'h4,                  32'hF840_8022,  64'h0,                 1, 1);
    vecs[2]  = mk(0, 0, 0, 0, 64'h0,                  64'h8,                  w(64'h4),       64'h4,                 1, 2);
    vecs[3]  = mk(0, 0, 0, 0, 64'h0,                  64'hC,                  w(64'h8),       64'h8,                 1, 3);
    vecs[4]  = mk(0, 0, 0, 0, 64'h0,                  64'h10,                 w(64'hC),       64'hC,                 1, 4);
    vecs[5]  = mk(0, 0, 0, 0, 64'h0,                  64'h14,                 w(64'h10),      64'h10,                1, 5);
    vecs[6]  = mk(1, 1, 0, 0, 64'h80,                 64'h0,                  32'h0,          64'h0,                 0, 0);
    vecs[7]  = mk(0, 0, 0, 0, 64'h0,                  64'h4,                  32'hF840_8022,  64'h0,                 1, 1);
    vecs[8]  = mk(0, 0, 0, 0, 64'h0,                  64'h8,                  w(64'h4),       64'h4,                 1, 2);
    vecs[9]  = mk(0, 0, 1, 0, 64'h0,                  64'h8,                  w(64'h4),       64'h4,                 1, 2);
    vecs[10] = mk(0, 0, 1, 0, 64'h0,                  64'h8,                  w(64'h4),       64'h4,                 1, 2);
    vecs[11] = mk(0, 0, 1, 0, 64'h0,                  64'h8,                  w(64'h4),       64'h4,                 1, 2);
    vecs[12] = mk(0, 0, 0, 0, 64'h0,                  64'hC,                  w(64'h8),       64'h8,                 1, 3);
    vecs[13] = mk(0, 1, 0, 1, 64'h43,                 64'h40,                 32'h0,          64'h0,                 0, 3);
    vecs[14] = mk(0, 0, 0, 0, 64'h0,                  64'h44,                 32'hF840_8062,  64'h40,                1, 4);
    vecs[15] = mk(0, 1, 1, 0, 64'h100,                64'h100,                32'hF840_8062,  64'h40,                1, 4);
    vecs[16] = mk(0, 0, 1, 1, 64'h0,                  64'h100,                32'h0,          64'h0,                 0, 4);
    vecs[17] = mk(0, 0, 0, 0, 64'h0,                  64'h104,                w(64'h100),     64'h100,               1, 5);
    vecs[18] = mk(0, 1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFC, w(64'h104),     64'h104,               1, 6);
    vecs[19] = mk(0, 0, 0, 0, 64'h0,                  64'h0,                  32'h07BF_7FDE,  64'hFFFF_FFFF_FFFF_FFFC, 1, 7);
    vecs[20] = mk(0, 0, 0, 1, 64'h0,                  64'h4,                  32'h0,          64'h0,                 0, 7);
    vecs[21] = mk(0, 0, 1, 0, 64'h0,                  64'h4,                  32'h0,          64'h0,                 0, 7);
    vecs[22] = mk(0, 0, 0, 0, 64'h0,                  64'h8,                  w(64'h4),       64'h4,                 1, 8);

    for (int i = 0; i < 23; i++) begin
      step(vecs[i].rst, vecs[i].br, vecs[i].st, vecs[i].fl, vecs[i].tgt);
      chk($sformatf("v%0d imem_addr", i), imem_addr, vecs[i].e_addr);
      chk($sformatf("v%0d instr_D", i), {32'h0, instr_D}, {32'h0, vecs[i].e_instr});
      chk($sformatf("v%0d pc_D", i), pc_D, vecs[i].e_pc);
      chk($sformatf("v%0d valid_D", i), {63'h0, valid_D}, {63'h0, vecs[i].e_valid});
      chk($sformatf("v%0d fetch_count", i), {32'h0, fetch_count}, {32'h0, vecs[i].e_cnt});
      chk($sformatf("v%0d no_x", i),
          {63'h0, $isunknown({imem_addr, instr_D, pc_D, valid_D, fetch_count})}, 64'h0);
    end

    // Saturation: preload the counter to 0xFFFFFFFE across a stalled edge, then load three times.
    @(negedge clk);
    reset = 1'b0; pcsrc = 1'b0; stall = 1'b1; flush = 1'b0;
    force dut.cnt_d = 32'hFFFF_FFFE;
    @(posedge clk);
    #1;
    release dut.cnt_d;
    chk("sat preload", {32'h0, fetch_count}, 64'hFFFF_FFFE);
    chk("sat stall addr", imem_addr, 64'h8);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 0, 64'h0);
      chk($sformatf("sat load%0d fetch_count", k), {32'h0, fetch_count}, 64'hFFFF_FFFF);
      chk($sformatf("sat load%0d imem_addr", k), imem_addr, 64'hC + 64'(4 * k));
    end
    step(0, 0, 1, 0, 64'h0);
    chk("sat stall hold", {32'h0, fetch_count}, 64'hFFFF_FFFF);

    // A reset after saturation clears the counter and restarts from address 0.
    step(1, 0, 0, 0, 64'h0);
    chk("rst after sat count", {32'h0, fetch_count}, 64'h0);
    step(0, 0, 0, 0, 64'h0);
    chk("rst after sat instr", {32'h0, instr_D}, {32'h0, 32'hF840_8022});
    chk("rst after sat addr", imem_addr, 64'h4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
